// File: rtl/riscv_pkg.sv
// Shared load/store constants: funct3 encodings, LSU state encoding and timeout default.
package riscv_pkg;

    localparam int unsigned TimeoutDefault = 255;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    // Unknown access sizes are reported as alignment faults.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            Funct3B, Funct3Bu: mis = 1'b0;
            Funct3H, Funct3Hu: mis = addr_lo[0];
            Funct3W:           mis = |addr_lo;
            default:           mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / data replication and load extract + extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i)
            Funct3B, Funct3Bu: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            Funct3H, Funct3Hu: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = shifted;
        case (funct3_i)
            Funct3B:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            Funct3Bu: rdata_o = {24'h0, shifted[7:0]};
            Funct3H:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            Funct3Hu: rdata_o = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the core to a req/gnt/rvalid word bus,
// with alignment fault detection and a bus timeout.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e      state_q, state_d;
    logic [31:0]     addr_q, wdata_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            misaligned_q, misaligned_d;
    logic            bus_err_q, bus_err_d;
    logic            capture;
    logic [3:0]      be;
    logic [31:0]     load_data;

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (be),
        .wdata_o   (mem_wdata),
        .rdata_o   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        rsp_valid_d  = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d      = StDone;
                        rsp_valid_d  = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = StReq;
                        capture = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                // Completion wins over timeout; timeout wins over moving to WAIT.
                if (mem_gnt && (we_q || mem_rvalid)) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    if (!we_q) rsp_rdata_d = load_data;
                end else if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                end else if (mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                end else if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            rsp_rdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_valid_q  <= rsp_valid_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            if (capture) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                we_q     <= req_we;
                funct3_q <= req_funct3;
            end
        end
    end

    assign stall      = req_valid && (state_q != StDone);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = (state_q == StReq);
    assign mem_we     = we_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_be     = mem_req ? be : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts every cycle's outputs.
module tb_load_store_unit;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, rsp_valid, misaligned, bus_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        stall;
        logic        mem_req;
        logic        rsp_valid;
        logic        mis;
        logic        berr;
        logic        chk_mem;
        logic        chk_be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_c = '0;
    logic        exp_on = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          stall_cycles = 0, req_cycles = 0, rsp_count = 0, mis_count = 0, berr_count = 0;
    logic [31:0] last_rdata = '0, last_addr = '0, last_wdata = '0;
    logic [3:0]  last_be = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, req);
    endtask

    // Reference rules, expressed as access sizes and plain arithmetic.
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic [1:0] a);
        int sz = size_of(f3);
        if (sz == 0) return 1'b1;
        return (int'(a) % sz) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
        int sz = size_of(f3);
        if (sz == 1) return 4'(1 << a);
        if (sz == 2) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        if (sz == 1) return 32'(wd[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(a));
        case (f3)
            3'd0: begin v &= 32'hFF;   if (v >= 32'h80)   v -= 32'h100;   end
            3'd4: v &= 32'hFF;
            3'd1: begin v &= 32'hFFFF; if (v >= 32'h8000) v -= 32'h10000; end
            3'd5: v &= 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    initial forever begin
        @(negedge clk);
        if (stall) stall_cycles++;
        if (mem_req) begin
            req_cycles++;
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
        end
        if (rsp_valid) begin
            rsp_count++;
            last_rdata = rsp_rdata;
        end
        if (misaligned) mis_count++;
        if (bus_err) berr_count++;
        if (exp_on) begin
            check("stall", 32'(stall), 32'(exp_c.stall));
            check("mem_req", 32'(mem_req), 32'(exp_c.mem_req));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_c.rsp_valid));
            check("rsp_rdata", rsp_rdata, exp_c.rdata);
            check("misaligned", 32'(misaligned), 32'(exp_c.mis));
            check("bus_err", 32'(bus_err), 32'(exp_c.berr));
            if (exp_c.chk_mem) begin
                check("mem_addr", mem_addr, exp_c.addr);
                check("mem_we", 32'(mem_we), 32'(exp_c.we));
            end
            if (exp_c.chk_be) begin
                check("mem_be", 32'(mem_be), 32'(exp_c.be));
                check("mem_wdata", mem_wdata, exp_c.wdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_noise();
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
    endtask

    // gnt_at / rv_at: REQ+WAIT cycle index at which the bus grants / returns data.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gnt_at, input int rv_at);
        int   n;
        int   comp;
        logic berr;
        logic mis;
        logic [1:0] a;
        a    = addr[1:0];
        mis  = exp_mis(f3, a);
        berr = 1'b0;
        n    = 0;
        next_cycle();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_noise();
        exp_c = '0; exp_c.stall = 1'b1; exp_on = 1'b1;
        if (!mis) begin
            comp = we ? gnt_at : rv_at;
            if (comp < int'(TO)) n = comp + 1;
            else begin n = TO; berr = 1'b1; end
        end
        for (int k = 0; k < n; k++) begin
            next_cycle();
            mem_gnt    = (k == gnt_at) || (k > gnt_at && $urandom_range(0, 1) == 1);
            mem_rvalid = (k == rv_at) || (we && $urandom_range(0, 1) == 1);
            mem_rdata  = (k == rv_at) ? rd : $urandom;
            exp_c         = '0;
            exp_c.stall   = 1'b1;
            exp_c.mem_req = (k <= gnt_at);
            exp_c.chk_mem = (k <= gnt_at);
            exp_c.chk_be  = we && (k <= gnt_at);
            exp_c.we      = we;
            exp_c.addr    = {addr[31:2], 2'b00};
            exp_c.be      = exp_be(f3, a);
            exp_c.wdata   = exp_wd(f3, wd);
        end
        next_cycle();
        mem_noise();
        exp_c           = '0;
        exp_c.rsp_valid = 1'b1;
        exp_c.mis       = mis;
        exp_c.berr      = berr;
        exp_c.rdata     = (mis || berr || we) ? 32'h0 : exp_load(f3, a, rd);
        @(negedge clk);
        #1;
        repeat ($urandom_range(0, 2)) begin
            next_cycle();
            req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom;
            mem_noise();
            exp_c = '0;
        end
    endtask

    initial begin
        int s0, r0, m0, b0, q0;
        logic [2:0]  st_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          g, rv;

        exp_c = '0; exp_c.chk_mem = 1'b1; exp_c.chk_be = 1'b1; exp_on = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_c = '0;

        // Directed cases with hand-computed results.
        s0 = stall_cycles; r0 = rsp_count;
        run_txn(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 1, -1);
        check("sw_stall_cycles", 32'(stall_cycles - s0), 32'd3);
        check("sw_rsp_count", 32'(rsp_count - r0), 32'd1);
        check("sw_addr", last_addr, 32'h100);
        check("sw_be", 32'(last_be), 32'hF);
        check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        check("sw_rdata", last_rdata, 32'h0);

        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
        check("lb_103", last_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
        check("lbu_103", last_rdata, 32'h0000_0080);

        run_txn(1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 32'h0, 0, -1);
        check("sh_be", 32'(last_be), 32'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_addr", last_addr, 32'h100);

        s0 = stall_cycles; m0 = mis_count; q0 = req_cycles;
        run_txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0);
        check("lw_mis_stall", 32'(stall_cycles - s0), 32'd1);
        check("lw_mis_pulse", 32'(mis_count - m0), 32'd1);
        check("lw_mis_no_req", 32'(req_cycles - q0), 32'd0);

        s0 = stall_cycles; b0 = berr_count; q0 = req_cycles;
        run_txn(1'b0, 3'd2, 32'h200, 32'h0, 32'h1234_5678, 0, 99);
        check("to_berr_pulse", 32'(berr_count - b0), 32'd1);
        check("to_stall_cycles", 32'(stall_cycles - s0), 32'd1 + TO);
        check("to_req_cycles", 32'(req_cycles - q0), 32'd1);
        check("to_rdata", last_rdata, 32'h0);

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size_of(f3) == 2) addr[0] = 1'b0;
                if (size_of(f3) == 4) addr[1:0] = 2'b00;
            end
            g  = ($urandom_range(0, 9) == 0) ? int'(TO) + 1 : $urandom_range(0, 3);
            rv = we ? -1 : g + (($urandom_range(0, 9) == 0) ? int'(TO) : $urandom_range(0, 3));
            run_txn(we, f3, addr, $urandom, $urandom, g, rv);
        end

        // Reset while waiting for read data abandons the access.
        r0 = rsp_count;
        next_cycle();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_c = '0; exp_c.stall = 1'b1;
        next_cycle();
        mem_gnt = 1'b1;
        exp_c = '0; exp_c.stall = 1'b1; exp_c.mem_req = 1'b1; exp_c.chk_mem = 1'b1;
        exp_c.addr = 32'h300;
        next_cycle();
        mem_gnt = 1'b0;
        #2;
        rst = 1'b1; req_valid = 1'b0;
        exp_c = '0; exp_c.chk_mem = 1'b1; exp_c.chk_be = 1'b1;
        next_cycle();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        exp_c = '0;
        next_cycle();
        mem_rvalid = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        #1;
        check("rst_no_rsp", 32'(rsp_count - r0), 32'd0);

        exp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
